// File: rtl/b_tile_loader_if.sv
// b_tile_loader_if: job control, B-memory read port and PE weight-row write port.
// Ports: start/B_load in, B_load_done/load_overrun out,
//   mem_rd_en/mem_addr out, mem_rd_data/mem_rd_valid in,
//   b_wr_en/b_wr_row/b_wr_data out (master = loader side, slave = host side).
interface b_tile_loader_if #(
    parameter int W      = 8,
    parameter int N      = 16,
    parameter int ADDR_W = 8
);
    localparam int ROW_W = $clog2(N);

    logic              start;
    logic              B_load;
    logic              B_load_done;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [N*W-1:0]    mem_rd_data;
    logic              mem_rd_valid;
    logic              b_wr_en;
    logic [ROW_W-1:0]  b_wr_row;
    logic [N*W-1:0]    b_wr_data;
    logic              load_overrun;

    modport master (
        input  start, B_load, mem_rd_data, mem_rd_valid,
        output B_load_done, mem_rd_en, mem_addr,
        output b_wr_en, b_wr_row, b_wr_data, load_overrun
    );

    modport slave (
        output start, B_load, mem_rd_data, mem_rd_valid,
        input  B_load_done, mem_rd_en, mem_addr,
        input  b_wr_en, b_wr_row, b_wr_data, load_overrun
    );
endinterface

// File: rtl/b_tile_loader.sv
// b_tile_loader: walks the N x N tiles of B (k inner, c outer), reads N rows
// per tile from B memory and streams them into the PE weight rows.
// Ports: clk, rst_n (async, active-low), bus (b_tile_loader_if.master):
//   start/B_load in, B_load_done/load_overrun out, memory read port,
//   PE row write port (b_wr_*), write data passed straight from mem_rd_data.
module b_tile_loader #(
    parameter int W             = 8,
    parameter int N             = 16,
    parameter int DATA_B_SIZE_X = 64,
    parameter int DATA_B_SIZE_Y = 64,
    parameter int ADDR_W        = $clog2(DATA_B_SIZE_X*DATA_B_SIZE_Y/N)
) (
    input logic             clk,
    input logic             rst_n,
    b_tile_loader_if.master bus
);
    localparam int KT    = DATA_B_SIZE_Y / N;
    localparam int CT    = DATA_B_SIZE_X / N;
    localparam int ROW_W = $clog2(N);
    localparam int KW    = (KT > 1) ? $clog2(KT) : 1;
    localparam int CW    = (CT > 1) ? $clog2(CT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [KW-1:0]     k_idx;
    logic [CW-1:0]     c_idx;
    logic [ROW_W-1:0]  iss_r;
    logic [ROW_W-1:0]  ret_r;
    logic              overrun;

    logic              busy;
    logic              accept;
    logic              last_ret;
    logic              last_iss;
    logic [ADDR_W-1:0] row_addr;

    assign busy     = (state == S_ISSUE) || (state == S_DRAIN);
    assign accept   = busy && bus.mem_rd_valid;
    assign last_ret = accept && (ret_r == ROW_W'(N - 1));
    assign last_iss = (iss_r == ROW_W'(N - 1));

    // Row-major B: tile row r of tile (k,c) is word (k*N + r)*CT + c.
    assign row_addr = ADDR_W'((32'(k_idx) * N + 32'(iss_r)) * CT
                              + 32'(c_idx));

    assign bus.mem_rd_en    = (state == S_ISSUE);
    assign bus.mem_addr     = bus.mem_rd_en ? row_addr : '0;
    assign bus.b_wr_en      = accept;
    assign bus.b_wr_row     = ret_r;
    assign bus.b_wr_data    = bus.mem_rd_data;
    // A start in the DONE cycle aborts the tile, so the pulse is withheld.
    assign bus.B_load_done  = (state == S_DONE) && !bus.start;
    assign bus.load_overrun = overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            k_idx   <= '0;
            c_idx   <= '0;
            iss_r   <= '0;
            ret_r   <= '0;
            overrun <= 1'b0;
        end else begin
            if (bus.start) begin
                overrun <= 1'b0;
            end else if (state != S_IDLE && bus.B_load) begin
                overrun <= 1'b1;
            end

            if (bus.start && state != S_IDLE) begin
                state <= S_IDLE;
                k_idx <= '0;
                c_idx <= '0;
            end else begin
                if (bus.start) begin
                    k_idx <= '0;
                    c_idx <= '0;
                end
                case (state)
                    S_IDLE: begin
                        if (bus.B_load) begin
                            state <= S_ISSUE;
                            iss_r <= '0;
                            ret_r <= '0;
                        end
                    end
                    S_ISSUE: begin
                        iss_r <= iss_r + 1'b1;
                        if (accept) ret_r <= ret_r + 1'b1;
                        if (last_ret) begin
                            state <= S_DONE;
                        end else if (last_iss) begin
                            state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (accept) ret_r <= ret_r + 1'b1;
                        if (last_ret) state <= S_DONE;
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        if (k_idx == KW'(KT - 1)) begin
                            k_idx <= '0;
                            if (c_idx == CW'(CT - 1)) begin
                                c_idx <= '0;
                            end else begin
                                c_idx <= c_idx + 1'b1;
                            end
                        end else begin
                            k_idx <= k_idx + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_b_tile_loader.sv
// tb_b_tile_loader: random + directed bench for b_tile_loader with an
// in-order variable-latency memory and a job-level reference model.
module tb_b_tile_loader;
    localparam int W      = 8;
    localparam int N      = 16;
    localparam int BX     = 64;
    localparam int BY     = 64;
    localparam int KT     = BY / N;
    localparam int CT     = BX / N;
    localparam int ADDR_W = $clog2(BX * BY / N);
    localparam int DW     = N * W;

    typedef struct {
        int a;
        int rdy;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    b_tile_loader_if #(.W(W), .N(N), .ADDR_W(ADDR_W)) bus ();

    b_tile_loader #(
        .W(W), .N(N), .DATA_B_SIZE_X(BX), .DATA_B_SIZE_Y(BY),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [DW-1:0] mem [1 << ADDR_W];
    req_t rq [$];
    int lat = 1;
    bit gap = 1'b0;

    bit job = 1'b0;
    int c0 = 0;
    int wcnt = 0;
    int mk = 0;
    int mc = 0;
    bit ovr = 1'b0;
    bit mreset = 1'b0;

    int done_count = 0;
    int done_cyc = 0;
    int rd_count = 0;
    int wr_n = 0;
    int addr_log [$];

    bit e_rd, e_wr, e_done, idle0;
    int idx;
    req_t t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [DW-1:0] a,
                       input logic [DW-1:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     nm, a, e, cyc);
        end
    endtask

    function automatic int taddr(input int k, input int c, input int r);
        return (k * N + r) * CT + c;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Memory returns plus per-cycle comparison against the job model.
    always begin
        @(posedge clk);
        #1;
        if (rq.size() > 0 && rq[0].rdy <= cyc && !(gap && (cyc % 2 == 1)))
        begin
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = mem[rq[0].a];
            void'(rq.pop_front());
        end else begin
            bus.mem_rd_valid = 1'b0;
            bus.mem_rd_data  = DW'({$urandom, $urandom, $urandom, $urandom});
        end
        @(negedge clk);
        if (bus.mem_rd_en) begin
            t.a   = int'(bus.mem_addr);
            t.rdy = cyc + lat;
            rq.push_back(t);
            rd_count++;
            addr_log.push_back(int'(bus.mem_addr));
        end
        if (bus.b_wr_en) wr_n++;
        if (bus.B_load_done) begin
            done_count++;
            done_cyc = cyc;
        end
        if (!rst_n || mreset) begin
            mreset = 1'b0;
            job    = 1'b0;
            mk     = 0;
            mc     = 0;
            ovr    = 1'b0;
            wcnt   = 0;
        end
        idx    = cyc - c0;
        e_rd   = job && idx < N;
        e_wr   = job && wcnt < N && bus.mem_rd_valid;
        e_done = job && wcnt == N && !bus.start;
        chk("mem_rd_en", bus.mem_rd_en, e_rd);
        if (e_rd) chk("mem_addr", bus.mem_addr, taddr(mk, mc, idx));
        chk("b_wr_en", bus.b_wr_en, e_wr);
        if (e_wr) begin
            chk("b_wr_row", bus.b_wr_row, wcnt);
            chk("b_wr_data", bus.b_wr_data, mem[taddr(mk, mc, wcnt)]);
        end
        chk("B_load_done", bus.B_load_done, e_done);
        chk("load_overrun", bus.load_overrun, ovr);
        if (!rst_n) begin
            chk("rst_mem_addr", bus.mem_addr, 0);
            chk("rst_b_wr_row", bus.b_wr_row, 0);
        end else begin
            idle0 = !job;
            if (bus.start) begin
                mk  = 0;
                mc  = 0;
                ovr = 1'b0;
                job = 1'b0;
            end
            if (idle0 && bus.B_load) begin
                job  = 1'b1;
                c0   = cyc + 1;
                wcnt = 0;
            end else if (!idle0 && !bus.start) begin
                if (bus.B_load) ovr = 1'b1;
                if (wcnt == N) begin
                    job = 1'b0;
                    mk++;
                    if (mk == KT) begin
                        mk = 0;
                        mc = (mc + 1) % CT;
                    end
                end else if (e_wr) begin
                    wcnt++;
                end
            end
        end
    end

    task automatic drain_mem();
        for (int i = 0; i < 100 && rq.size() > 0; i++) tick(1);
    endtask

    task automatic do_load(input int ovr_at, input bit with_start,
                           output int lat_seen);
        int d;
        int b;
        lat_seen = -1;
        drain_mem();
        addr_log.delete();
        wr_n = 0;
        d = done_count;
        b = cyc;
        bus.B_load = 1'b1;
        bus.start  = with_start;
        tick(1);
        bus.B_load = 1'b0;
        bus.start  = 1'b0;
        for (int i = 1; i < 300; i++) begin
            bus.B_load = (i == ovr_at);
            tick(1);
            if (done_count != d) break;
        end
        bus.B_load = 1'b0;
        chk("load_done_count", done_count, d + 1);
        if (done_count != d) lat_seen = done_cyc - b;
        chk("writes_per_tile", wr_n, N);
    endtask

    task automatic chk_addrs(input string nm, input int base);
        chk({nm, "_count"}, addr_log.size(), N);
        for (int r = 0; r < N && r < addr_log.size(); r++) begin
            chk(nm, addr_log[r], base + 4 * r);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int l;
        int d;
        int r;
        bit bl;
        bit st;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i] = DW'({$urandom, $urandom, $urandom, $urandom});
        end
        bus.start        = 1'b0;
        bus.B_load       = 1'b0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
        rst_n = 1'b0;
        tick(3);
        chk("reset_done", bus.B_load_done, 0);
        chk("reset_rd_en", bus.mem_rd_en, 0);
        chk("reset_overrun", bus.load_overrun, 0);
        rst_n = 1'b1;
        tick(2);
        pulse_start();
        tick(2);

        do_load(0, 1'b0, l);
        chk("latency_L1", l, 18);
        chk_addrs("tile_0_0", 0);
        do_load(0, 1'b0, l);
        chk_addrs("tile_1_0", 64);
        do_load(0, 1'b0, l);
        do_load(0, 1'b0, l);
        do_load(0, 1'b0, l);
        chk_addrs("tile_0_1", 1);
        for (int i = 0; i < 11; i++) do_load(0, 1'b0, l);
        do_load(0, 1'b0, l);
        chk_addrs("wrap_0_0", 0);

        do_load(0, 1'b1, l);
        chk_addrs("start_and_load", 0);

        lat = 3;
        gap = 1'b1;
        pulse_start();
        do_load(20, 1'b0, l);
        chk("drain_overrun", bus.load_overrun, 1);
        d = done_count;
        r = rd_count;
        tick(40);
        chk("no_extra_done", done_count, d);
        chk("no_extra_rd", rd_count, r);
        pulse_start();
        chk("start_clears_overrun", bus.load_overrun, 0);

        lat = 1;
        gap = 1'b0;
        drain_mem();
        addr_log.delete();
        wr_n = 0;
        d = done_count;
        bus.B_load = 1'b1;
        tick(1);
        bus.B_load = 1'b0;
        tick(7);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(10);
        chk("abort_no_done", done_count, d);
        chk("abort_issued", addr_log.size(), 8);
        chk("abort_writes", wr_n, 7);
        do_load(0, 1'b0, l);
        chk_addrs("after_abort", 0);

        lat = 3;
        gap = 1'b1;
        do_load(0, 1'b0, l);
        drain_mem();
        d = done_count;
        bus.B_load = 1'b1;
        tick(1);
        bus.B_load = 1'b0;
        tick(20);
        rst_n = 1'b0;
        #1;
        chk("async_rd_en", bus.mem_rd_en, 0);
        chk("async_wr_en", bus.b_wr_en, 0);
        chk("async_done", bus.B_load_done, 0);
        chk("async_overrun", bus.load_overrun, 0);
        chk("async_addr", bus.mem_addr, 0);
        chk("async_row", bus.b_wr_row, 0);
        #2;
        rst_n = 1'b1;
        mreset = 1'b1;
        tick(40);
        chk("reset_no_done", done_count, d);
        lat = 1;
        gap = 1'b0;
        do_load(0, 1'b0, l);
        chk_addrs("after_reset", 0);

        for (int i = 0; i < 600; i++) begin
            bl = ($urandom_range(0, 5) == 0);
            st = ($urandom_range(0, 80) == 0);
            if (!job && rq.size() != 0) bl = 1'b0;
            if (!job && bl) begin
                lat = $urandom_range(1, 4);
                gap = 1'(($urandom_range(0, 1)));
            end
            bus.B_load = bl;
            bus.start  = st;
            tick(1);
        end
        bus.B_load = 1'b0;
        bus.start  = 1'b0;
        tick(60);
        drain_mem();
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/b_tile_loader.md
B_TILE_LOADER -- requirements
Module: b_tile_loader

Interface
REQ-001 Parameters (name, default, meaning), each SHALL be provided:
- W, 8, element width in bits.
- N, 16, tile edge; the PE array holds an N x N block of B.
- DATA_B_SIZE_X, 64, columns of B.
- DATA_B_SIZE_Y, 64, rows of B.
- ADDR_W, $clog2(DATA_B_SIZE_X*DATA_B_SIZE_Y/N), memory word-address width.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; every flop is on its rising edge.
- rst_n, in, 1, reset, asynchronous assert and active-low.
- start, in, 1, job start pulse; clears the tile walk.
- B_load, in, 1, one-cycle request to load the next B tile.
- B_load_done, out, 1, one-cycle pulse when the tile is fully written.
- mem_rd_en, out, 1, read request to B memory.
- mem_addr, out, ADDR_W, word address; a word holds N elements of one B row (row-major).
- mem_rd_data, in, N*W, returned word.
- mem_rd_valid, in, 1, mem_rd_data is valid; returns are in order with latency >= 1.
- b_wr_en, out, 1, write strobe to the PE weight rows.
- b_wr_row, out, $clog2(N), tile row index being written.
- b_wr_data, out, N*W, row data, passed through from mem_rd_data.
- load_overrun, out, 1, sticky flag: B_load arrived while busy.

Function
REQ-003 The tile grid SHALL be KT = DATA_B_SIZE_Y/N row-tiles by CT = DATA_B_SIZE_X/N column-tiles, with counters k_idx and c_idx.
REQ-004 The walk order SHALL be k_idx inner (0..KT-1), then c_idx outer (0..CT-1); after (KT-1, CT-1) both counters SHALL wrap to 0.
REQ-005 The address of tile row r SHALL be mem_addr = (k_idx*N + r)*CT + c_idx, with r running 0..N-1.
REQ-006 The FSM SHALL have the states IDLE, ISSUE, DRAIN and DONE.
REQ-007 IDLE -> ISSUE SHALL occur on B_load=1; the issue and return counters clear.
REQ-008 In ISSUE, the block SHALL assert mem_rd_en for exactly N consecutive cycles with r = 0..N-1, then move to DRAIN.
REQ-009 Returns SHALL be accepted in both ISSUE and DRAIN: each mem_rd_valid gives b_wr_en=1, b_wr_row = return count, b_wr_data = mem_rd_data, combinationally in the same cycle.
REQ-010 When the N-th return is accepted, the FSM SHALL enter DONE; this can happen from ISSUE only if latency allows, otherwise from DRAIN.
REQ-011 In DONE, B_load_done SHALL be 1 for exactly one cycle, the tile counters advance per REQ-004, and the FSM returns to IDLE.
REQ-012 Minimum latency SHALL be N + L + 1 cycles from B_load to B_load_done, where L is the memory read latency.
REQ-013 mem_rd_valid in IDLE or DONE SHALL be ignored: no b_wr_en, no counter change.
REQ-014 B_load in ISSUE, DRAIN or DONE SHALL be ignored and set load_overrun=1; load_overrun clears only on reset or start.
REQ-015 start=1 SHALL clear k_idx, c_idx and load_overrun, and from any non-IDLE state SHALL abort to IDLE with no B_load_done; returns still in flight are then dropped per REQ-013.
REQ-016 When start and B_load are both 1 in IDLE, the counters SHALL clear and the load SHALL be accepted for tile (0,0).
REQ-017 b_wr_en SHALL never be asserted more than N times per tile.

Reset
REQ-018 While rst_n=0 the block SHALL be asynchronously held with:
- state = IDLE;
- k_idx, c_idx and all internal counters = 0;
- B_load_done, mem_rd_en, b_wr_en and load_overrun = 0;
- mem_addr and b_wr_row = 0.
REQ-019 Reset deasserted mid-tile SHALL restart cleanly from IDLE at tile (0,0), with no B_load_done.

Verification
REQ-020 The bench SHALL cover, with defaults (KT=CT=4, CT stride 4) and L=1 unless stated:
- Reset then start, then B_load: mem_addr = 0,4,...,60 on 16 consecutive cycles; 16 b_wr_en with rows 0..15; a single B_load_done pulse 18 cycles after B_load.
- Second B_load: addresses 64,68,...,124 for tile (1,0). Fifth B_load: addresses 1,5,...,61 for tile (0,1).
- 16 B_loads complete, then a 17th: addresses 0,4,...,60, i.e. the walk wraps to tile (0,0).
- L=3 with mem_rd_valid gapped every other cycle: exactly 16 writes in order, then B_load_done; B_load issued during DRAIN gives load_overrun=1 and no extra tile.
- start asserted during ISSUE at r=7: return to IDLE, no B_load_done, late returns give no b_wr_en, next B_load fetches tile (0,0).
- rst_n pulsed low for a half cycle during DRAIN: outputs 0 immediately, before the next clock edge.
